// File: rtl/wave_capture_pkg.sv
// Shared constants for the waveform capture/display pair: FSM encodings and RAM geometry.
package wave_capture_pkg;

    localparam logic [1:0] ST_ARMED  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    localparam int WAVE_SAMPLES = 256;
    localparam int WAVE_ADDR_W  = 9;

endpackage

// File: rtl/dffr.sv
// Generic D flip-flop with synchronous active-high reset to zero.
module dffr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/wave_capture.sv
// Arms on a negative-to-non-negative zero crossing, fills the undisplayed RAM half with
// 256 offset-binary samples, then flips the displayed half during display idle.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = WAVE_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    output logic [ADDR_W-1:0]   write_address,
    output logic                write_enable,
    output logic [7:0]          write_sample,
    output logic                read_index
);

    localparam int CNT_W = ADDR_W - 1;

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] count, count_d;
    logic             read_index_d;
    logic             prev_neg, prev_neg_d;
    logic             sign;
    logic             trigger;

    dffr #(.WIDTH(2))     u_state      (.clk(clk), .reset(reset), .d(state_d),      .q(state));
    dffr #(.WIDTH(CNT_W)) u_count      (.clk(clk), .reset(reset), .d(count_d),      .q(count));
    dffr #(.WIDTH(1))     u_read_index (.clk(clk), .reset(reset), .d(read_index_d), .q(read_index));
    dffr #(.WIDTH(1))     u_prev_neg   (.clk(clk), .reset(reset), .d(prev_neg_d),   .q(prev_neg));

    assign sign       = new_sample_in[SAMPLE_W-1];
    assign trigger    = new_sample_ready & prev_neg & ~sign;
    assign prev_neg_d = new_sample_ready ? sign : prev_neg;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d      = state;
        count_d      = count;
        read_index_d = read_index;
        case (state)
            ST_ARMED: begin
                if (trigger) begin
                    state_d = ST_ACTIVE;
                    count_d = '0;
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    count_d = count + 1'b1;
                    if (count == {CNT_W{1'b1}}) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wave_display_idle) begin
                    read_index_d = ~read_index;
                    state_d      = ST_ARMED;
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    // Combinational write port so the synchronous RAM captures the sample on this same edge.
    assign write_enable  = (state == ST_ACTIVE) & new_sample_ready;
    assign write_address = {~read_index, count};
    assign write_sample  = {~sign, new_sample_in[SAMPLE_W-2 -: 7]};

endmodule

// File: tb/tb_wave_capture.sv
// Randomized scoreboard bench for wave_capture against a sample-counting reference model.
module tb_wave_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    always #5 clk = ~clk;

    wave_capture #(.SAMPLE_W(16), .ADDR_W(9)) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    typedef struct {
        logic [8:0] addr;
        logic [7:0] sample;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Reference model: waiting for a crossing, filling, or holding a full buffer.
    typedef enum {M_SEEK, M_FILL, M_HOLD} mphase_t;
    mphase_t m_phase    = M_SEEK;
    int      m_written  = 0;
    bit      m_ri       = 1'b0;
    bit      m_prev_neg = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] display_byte(input logic [15:0] s);
        logic [7:0] hi;
        hi = s[15:8];
        return hi + 8'd128;
    endfunction

    // One clock cycle: apply inputs, predict, check static outputs, advance the model.
    task automatic step(input logic rst, input logic rdy, input logic [15:0] din, input logic idle);
        wr_t w;
        logic [8:0] exp_addr;
        reset             = rst;
        new_sample_ready  = rdy;
        new_sample_in     = din;
        wave_display_idle = idle;
        exp_addr = {~m_ri, 8'(m_written % 256)};
        if (!rst && rdy && m_phase == M_FILL) begin
            w.addr   = exp_addr;
            w.sample = display_byte(din);
            exp_q.push_back(w);
        end
        #2;
        if (!rst) begin
            check("read_index", 32'(read_index), 32'(m_ri));
            check("write_address", 32'(write_address), 32'(exp_addr));
        end
        @(posedge clk);
        if (rst) begin
            m_phase = M_SEEK; m_written = 0; m_ri = 1'b0; m_prev_neg = 1'b0;
        end else begin
            case (m_phase)
                M_SEEK: if (rdy && m_prev_neg && !din[15]) begin
                    m_phase = M_FILL; m_written = 0;
                end
                M_FILL: if (rdy) begin
                    m_written++;
                    if (m_written == 256) begin m_phase = M_HOLD; m_written = 0; end
                end
                M_HOLD: if (idle) begin
                    m_ri = ~m_ri; m_phase = M_SEEK;
                end
            endcase
            if (rdy) m_prev_neg = din[15];
        end
        #1;
    endtask

    task automatic strobe(input logic [15:0] din);
        step(1'b0, 1'b1, din, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    // Monitor: every DUT write must match the oldest prediction.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(write_address), 32'h1ff_ffff);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", 32'(write_address), 32'(w.addr));
                check("write_sample", 32'(write_sample), 32'(w.sample));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; new_sample_ready = 1'b0; new_sample_in = '0; wave_display_idle = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);

        // Quiet after reset.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            check("idle_we", 32'(write_enable), 32'd0);
            check("idle_addr", 32'(write_address), 32'h100);
        end

        // Crossing 8000 -> 0100 arms; 1234 is the first write (8'h92 at 9'h100).
        strobe(16'h8000);
        strobe(16'h0100);
        strobe(16'h1234);
        for (int i = 0; i < 255; i++) begin
            strobe(16'($urandom));
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 16'h0000, 1'($urandom));
        end
        strobe(16'h4000);                    // buffer full: no write
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);

        // Flip with a simultaneous strobe: sample only updates the sign history.
        step(1'b0, 1'b1, 16'h0100, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0);

        // No negative-to-non-negative edge here.
        strobe(16'h0100);
        strobe(16'h7FFF);
        strobe(16'hFF00);
        strobe(16'hFE00);

        // Zero counts as non-negative; then 100 writes into half 0.
        strobe(16'h0000);
        for (int i = 0; i < 100; i++) strobe(16'($urandom));

        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        check("post_reset_ri", 32'(read_index), 32'd0);
        check("post_reset_addr", 32'(write_address), 32'h100);

        strobe(16'hC000);
        strobe(16'h0001);
        for (int i = 0; i < 20; i++) strobe(16'($urandom));

        // Free-running random traffic, including idle pulses in every phase.
        for (int i = 0; i < 3000; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 9) == 0);
        end

        step(1'b0, 1'b0, 16'h0000, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Upstream producer for the waveform display RAM.
- Watches the codec sample stream and arms on a positive-going zero crossing.
- After triggering, writes 256 display-format samples into the half of the double-buffered 512x8 RAM that the display is not reading.
- Once the display reports idle, flips `read_index` so the display scans the fresh buffer, then re-arms.

Parameters:
- SAMPLE_W, 16: width of the incoming signed two's-complement codec sample.
- ADDR_W, 9: RAM address width. Each half holds 2^(ADDR_W-1) = 256 samples. The MSB of the address selects the buffer half.

Ports:
- `clk`  input  1: system clock.
- `reset`  input  1: synchronous, active-high reset.
- `new_sample_ready`  input  1: one-cycle strobe; `new_sample_in` is valid this cycle.
- `new_sample_in`  input  SAMPLE_W: signed sample from the codec.
- `wave_display_idle`  input  1: high while the display is not reading the RAM (vertical blanking).
- `write_address`  output  ADDR_W: RAM write address.
- `write_enable`  output  1: RAM write strobe.
- `write_sample`  output  8: display-format sample (offset binary).
- `read_index`  output  1: buffer half the display reads; the capture side writes the other half.

Behaviour:
- One clock (`clk`); synchronous active-high `reset`. All registers update on the rising edge only.
- Registered state:
  - `state`: ARMED, ACTIVE or WAIT.
  - `count[7:0]`: write pointer.
  - `read_index`.
  - `prev_neg`: sign bit of the most recent sample.
- Reset values: `state`=ARMED, `count`=0, `read_index`=0, `prev_neg`=0.
  - Resulting output values: `write_enable`=0, `write_address`=9'h100.
- `prev_neg` loads `new_sample_in[SAMPLE_W-1]` on every `new_sample_ready`, in every state.
- Trigger condition: `new_sample_ready` AND `prev_neg`=1 AND `new_sample_in[SAMPLE_W-1]`=0 (negative to non-negative).
  - Zero counts as non-negative.
  - negative->negative, positive->positive and positive->negative never trigger.
- State transitions:
  - ARMED: on trigger, go to ACTIVE with `count`<=0. The triggering sample itself is not written. Otherwise stay in ARMED.
  - ACTIVE: on each `new_sample_ready`, write the sample and increment `count`. On the write with `count`=255, go to WAIT. `count` wraps to 0; there is no write beyond 255. `count` holds between strobes.
  - WAIT: samples are ignored for writing (`prev_neg` still tracks). When `wave_display_idle`=1, `read_index` <= ~`read_index` and go to ARMED in the same edge.
- Write outputs are combinational from registered state plus the current inputs, giving zero-cycle latency to the synchronous-write RAM:
  - `write_enable` = (state==ACTIVE) & `new_sample_ready`.
  - `write_address` = {~`read_index`, `count`}.
  - `write_sample` = {~`new_sample_in[SAMPLE_W-1]`, `new_sample_in[SAMPLE_W-2:SAMPLE_W-8]`}, i.e. top byte + 128. This maps -32768 to 8'h00 and 0 to 8'h80.
- Timing of the buffer flip:
  - `wave_display_idle` is sampled only in WAIT; idle pulses during ARMED or ACTIVE are ignored.
  - `read_index` changes only on the WAIT->ARMED edge. Each captured buffer therefore flips exactly once.
- Simultaneous events in WAIT:
  - `new_sample_ready` together with `wave_display_idle`: flip and move to ARMED. The sample updates `prev_neg`. No write and no trigger in that cycle.
  - A trigger can occur on the next strobe.
- `reset` mid-operation, in any state: the next edge restores all reset values. A partially written half is abandoned and is never displayed (`read_index` returns to 0).
- No back-pressure toward the codec. Strobes closer than 1 cycle apart are not supported; the codec guarantees spacing of 1 or more cycles.

Decomposition:
- Shared package:
  - State encodings: ARMED=2'd0, ACTIVE=2'd1, WAIT=2'd2. Encoding 2'd3 recovers to ARMED.
  - WAVE_SAMPLES=256 and WAVE_ADDR_W=9, also used by `wave_display`.
- All registers use the existing `dffr` flop.
- No separate sub-module. Zero-cross detection is one flop and one gate, kept inline.

Test Plan:
- Reset, then idle inputs for 10 cycles -> `read_index`=0, `write_enable`=0, `write_address`=9'h100 throughout.
- Strobe 16'h8000, then 16'h0100, then 16'h1234 -> no write on the first two strobes; the third strobe produces `write_enable`=1 for one cycle with `write_address`=9'h100 and `write_sample`=8'h92.
- After the trigger, 256 strobes with `wave_display_idle`=0 -> writes at 9'h100..9'h1FF in order. A 257th strobe produces no write. `read_index` stays 0.
- In WAIT, raise `wave_display_idle` -> `read_index`=1 the next cycle. After the next trigger, writes start at 9'h000.
- Strobes of 16'h0100, 16'h7FFF, 16'hFF00, 16'hFE00 (no negative->non-negative edge) -> `write_enable` never asserts and the state stays ARMED.
- Assert `reset` after 100 ACTIVE writes into the half at 9'h000 (`read_index`=1) -> next cycle `read_index`=0, ARMED, `write_address`=9'h100. A fresh trigger then writes from 9'h100.
